// File: rtl/sp_inst_feeder.sv
`default_nettype none
// ============================================================================
// Module   : sp_inst_feeder
// Purpose  : Instruction-supply end of a single-cycle core's fetch interface.
//            Holds a program ROM that is loaded while idle. On start it returns
//            the word addressed by the core's inst_addr every cycle for
//            exec_num instructions. It counts retirements on out_valid and
//            flags protocol violations with a sticky error code.
// Ports    : clk, rst_n         - clock, synchronous active-low reset
//            start, exec_num    - run trigger and instruction count (IDLE only)
//            prog_we/addr/data  - ROM write port (IDLE only)
//            inst_addr          - byte fetch address from the core
//            out_valid          - core retired one instruction this cycle
//            in_valid, inst     - registered fetch response
//            busy, done, err    - run status (done and err are sticky)
//            err_code           - 1 timeout, 2 out_valid fell, 3 extra, 4 bad addr
//            retired_cnt        - instructions retired in the current run
// Revision : 1.0 - initial release
// ============================================================================
module sp_inst_feeder #(
    parameter int ROM_AW  = 9,
    parameter int MAX_LAT = 10,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [CNT_W-1:0]  exec_num,
    input  logic              prog_we,
    input  logic [ROM_AW-1:0] prog_addr,
    input  logic [31:0]       prog_data,
    input  logic [31:0]       inst_addr,
    input  logic              out_valid,
    output logic              in_valid,
    output logic [31:0]       inst,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [2:0]        err_code,
    output logic [CNT_W-1:0]  retired_cnt
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FEED  = 3'd1,
        S_DRAIN = 3'd2,
        S_DONE  = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    localparam logic [2:0]       c_err_none    = 3'd0;
    localparam logic [2:0]       c_err_timeout = 3'd1;
    localparam logic [2:0]       c_err_fell    = 3'd2;
    localparam logic [2:0]       c_err_extra   = 3'd3;
    localparam logic [2:0]       c_err_addr    = 3'd4;
    localparam logic [CNT_W-1:0] c_max_lat     = CNT_W'(MAX_LAT);
    localparam logic [CNT_W-1:0] c_one         = CNT_W'(1);

    // Program storage; deliberately outside the reset domain so a program
    // survives a reset and can be rerun.
    logic [31:0] r_rom [2**ROM_AW];

    state_t            r_state_q,       w_state_d;
    logic              r_in_valid_q,    w_in_valid_d;
    logic [31:0]       r_inst_q,        w_inst_d;
    logic              r_busy_q,        w_busy_d;
    logic              r_done_q,        w_done_d;
    logic              r_err_q,         w_err_d;
    logic [2:0]        r_err_code_q,    w_err_code_d;
    logic [CNT_W-1:0]  r_retired_cnt_q, w_retired_cnt_d;
    logic [CNT_W-1:0]  r_issue_cnt_q,   w_issue_cnt_d;
    logic [CNT_W-1:0]  r_lat_cnt_q,     w_lat_cnt_d;
    logic [CNT_W-1:0]  r_exec_num_q,    w_exec_num_d;
    logic              r_seen_out_q,    w_seen_out_d;

    logic [31:0]       w_rom_rdata;
    logic              w_bad_addr;
    logic              w_timeout;
    logic              w_fell;
    logic [2:0]        w_err_sel;
    logic [CNT_W-1:0]  w_ret_inc;
    logic [CNT_W-1:0]  w_issue_inc;
    logic [CNT_W-1:0]  w_lat_inc;

    always_ff @(posedge clk) begin
        if (r_state_q == S_IDLE && prog_we) begin
            r_rom[prog_addr] <= prog_data;
        end
    end

    always_comb begin
        w_rom_rdata = r_rom[inst_addr[ROM_AW+1:2]];
        // Misaligned, or beyond the ROM word range.
        w_bad_addr  = (inst_addr[1:0] != 2'b00) || (inst_addr[31:ROM_AW+2] != '0);
        w_ret_inc   = r_retired_cnt_q + c_one;
        w_issue_inc = r_issue_cnt_q + c_one;
        w_lat_inc   = r_lat_cnt_q + c_one;
        // Latency only runs once something has been issued and until the
        // first retirement is seen.
        w_timeout   = !r_seen_out_q && !out_valid && (r_issue_cnt_q != '0) &&
                      (w_lat_inc >= c_max_lat);
        w_fell      = r_seen_out_q && !out_valid && (r_retired_cnt_q < r_exec_num_q);

        w_state_d       = r_state_q;
        w_in_valid_d    = r_in_valid_q;
        w_inst_d        = r_inst_q;
        w_busy_d        = r_busy_q;
        w_done_d        = r_done_q;
        w_err_d         = r_err_q;
        w_err_code_d    = r_err_code_q;
        w_retired_cnt_d = r_retired_cnt_q;
        w_issue_cnt_d   = r_issue_cnt_q;
        w_lat_cnt_d     = r_lat_cnt_q;
        w_exec_num_d    = r_exec_num_q;
        w_seen_out_d    = r_seen_out_q;
        w_err_sel       = c_err_none;

        case (r_state_q)
            S_IDLE: begin
                if (start) begin
                    w_exec_num_d    = exec_num;
                    w_issue_cnt_d   = '0;
                    w_lat_cnt_d     = '0;
                    w_retired_cnt_d = '0;
                    w_seen_out_d    = 1'b0;
                    if (exec_num == '0) begin
                        w_state_d = S_DONE;
                        w_done_d  = 1'b1;
                    end else begin
                        w_state_d = S_FEED;
                        w_busy_d  = 1'b1;
                    end
                end
            end
            S_FEED, S_DRAIN: begin
                // Priority order of simultaneous errors: addr > timeout > fell.
                if (r_state_q == S_FEED && w_bad_addr) begin
                    w_err_sel = c_err_addr;
                end else if (w_timeout) begin
                    w_err_sel = c_err_timeout;
                end else if (w_fell) begin
                    w_err_sel = c_err_fell;
                end else begin
                    if (out_valid) begin
                        w_retired_cnt_d = w_ret_inc;
                        w_seen_out_d    = 1'b1;
                    end else if (!r_seen_out_q && r_issue_cnt_q != '0) begin
                        w_lat_cnt_d = w_lat_inc;
                    end
                    if (r_state_q == S_FEED) begin
                        w_inst_d      = w_rom_rdata;
                        w_in_valid_d  = 1'b1;
                        w_issue_cnt_d = w_issue_inc;
                        if (w_issue_inc == r_exec_num_q) begin
                            w_state_d = S_DRAIN;
                        end
                    end else begin
                        w_in_valid_d = 1'b0;
                        w_inst_d     = '0;
                        if (out_valid && w_ret_inc == r_exec_num_q) begin
                            w_state_d = S_DONE;
                            w_done_d  = 1'b1;
                            w_busy_d  = 1'b0;
                        end
                    end
                end
            end
            S_DONE: begin
                if (out_valid) begin
                    w_err_sel = c_err_extra;
                end
            end
            default: begin
                // S_ERR: everything frozen until reset.
            end
        endcase

        if (w_err_sel != c_err_none) begin
            w_state_d    = S_ERR;
            w_err_d      = 1'b1;
            w_err_code_d = w_err_sel;
            w_in_valid_d = 1'b0;
            w_inst_d     = '0;
            w_busy_d     = 1'b0;
            w_done_d     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state_q       <= S_IDLE;
            r_in_valid_q    <= 1'b0;
            r_inst_q        <= '0;
            r_busy_q        <= 1'b0;
            r_done_q        <= 1'b0;
            r_err_q         <= 1'b0;
            r_err_code_q    <= c_err_none;
            r_retired_cnt_q <= '0;
            r_issue_cnt_q   <= '0;
            r_lat_cnt_q     <= '0;
            r_exec_num_q    <= '0;
            r_seen_out_q    <= 1'b0;
        end else begin
            r_state_q       <= w_state_d;
            r_in_valid_q    <= w_in_valid_d;
            r_inst_q        <= w_inst_d;
            r_busy_q        <= w_busy_d;
            r_done_q        <= w_done_d;
            r_err_q         <= w_err_d;
            r_err_code_q    <= w_err_code_d;
            r_retired_cnt_q <= w_retired_cnt_d;
            r_issue_cnt_q   <= w_issue_cnt_d;
            r_lat_cnt_q     <= w_lat_cnt_d;
            r_exec_num_q    <= w_exec_num_d;
            r_seen_out_q    <= w_seen_out_d;
        end
    end

    assign in_valid    = r_in_valid_q;
    assign inst        = r_inst_q;
    assign busy        = r_busy_q;
    assign done        = r_done_q;
    assign err         = r_err_q;
    assign err_code    = r_err_code_q;
    assign retired_cnt = r_retired_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_sp_inst_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_sp_inst_feeder
// Purpose  : Self-checking bench for sp_inst_feeder. Expected instruction
//            words are queued when a run is set up; a monitor pops and
//            compares them whenever in_valid is high. Status outputs are
//            checked at directed points of each scenario.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sp_inst_feeder;

    localparam int ROM_AW  = 9;
    localparam int MAX_LAT = 10;
    localparam int CNT_W   = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [CNT_W-1:0]  exec_num;
    logic              prog_we;
    logic [ROM_AW-1:0] prog_addr;
    logic [31:0]       prog_data;
    logic [31:0]       inst_addr;
    logic              out_valid;
    logic              in_valid;
    logic [31:0]       inst;
    logic              busy;
    logic              done;
    logic              err;
    logic [2:0]        err_code;
    logic [CNT_W-1:0]  retired_cnt;

    int checks = 0;
    int errors = 0;
    int iv_cnt = 0;

    logic [31:0] exp_q [$];
    logic [31:0] rom_model [0:15];
    logic [31:0] addr_tab  [0:7];

    sp_inst_feeder #(
        .ROM_AW  (ROM_AW),
        .MAX_LAT (MAX_LAT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .exec_num    (exec_num),
        .prog_we     (prog_we),
        .prog_addr   (prog_addr),
        .prog_data   (prog_data),
        .inst_addr   (inst_addr),
        .out_valid   (out_valid),
        .in_valid    (in_valid),
        .inst        (inst),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .err_code    (err_code),
        .retired_cnt (retired_cnt)
    );

    always #5 clk = ~clk;

    // Monitor: every cycle with in_valid high must match the next queued word.
    always @(negedge clk) begin
        if (in_valid) begin
            iv_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL inst_unexpected got %08h want none", inst);
            end else begin
                logic [31:0] w_exp;
                w_exp = exp_q.pop_front();
                if (inst !== w_exp) begin
                    errors++;
                    $display("FAIL inst_word got %08h want %08h", inst, w_exp);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, got, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        start     = 1'b0;
        out_valid = 1'b0;
        inst_addr = '0;
        prog_we   = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic push_exp(input int k);
        for (int i = 0; i < k; i++) begin
            logic [31:0] a;
            a = addr_tab[i];
            exp_q.push_back(rom_model[a[5:2]]);
        end
    endtask

    task automatic do_start(input int n);
        start     = 1'b1;
        exec_num  = CNT_W'(n);
        inst_addr = addr_tab[0];
        step();
        start = 1'b0;
    endtask

    // Drives the core side for edges cfrom..cto after the start edge: edge c
    // samples addr_tab[c-1] and out_valid when ovf <= c <= ovl.
    task automatic feed(input int cfrom, input int cto, input int n_addr,
                        input int ovf, input int ovl);
        for (int c = cfrom; c <= cto; c++) begin
            inst_addr = (c <= n_addr) ? addr_tab[c-1] : 32'h0;
            out_valid = (c >= ovf) && (c <= ovl);
            step();
        end
        out_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; exec_num = '0; prog_we = 1'b0;
        prog_addr = '0; prog_data = '0; inst_addr = '0; out_valid = 1'b0;
        for (int i = 0; i < 16; i++) rom_model[i] = 32'h0;
        for (int i = 0; i < 8; i++) addr_tab[i] = 32'h0;
        step();
        do_reset();

        // Reset state
        chk("rst_in_valid", {31'b0, in_valid}, 32'd0);
        chk("rst_inst", inst, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_err", {31'b0, err}, 32'd0);
        chk("rst_err_code", {29'b0, err_code}, 32'd0);
        chk("rst_retired", {16'b0, retired_cnt}, 32'd0);

        // Load program
        rom_model[0] = 32'h0C010005;
        rom_model[1] = 32'h0C020003;
        rom_model[2] = 32'h00221802;
        rom_model[3] = 32'h1C00FFFF;
        for (int i = 0; i < 4; i++) begin
            prog_we   = 1'b1;
            prog_addr = ROM_AW'(i);
            prog_data = rom_model[i];
            step();
        end
        prog_we = 1'b0;

        // Straight-line run of 4
        addr_tab[0] = 0; addr_tab[1] = 4; addr_tab[2] = 8; addr_tab[3] = 12;
        push_exp(4);
        do_start(4);
        chk("run4_busy", {31'b0, busy}, 32'd1);
        feed(1, 5, 4, 3, 6);
        chk("run4_done_early", {31'b0, done}, 32'd0);
        chk("run4_retired_mid", {16'b0, retired_cnt}, 32'd3);
        feed(6, 6, 4, 3, 6);
        chk("run4_done", {31'b0, done}, 32'd1);
        chk("run4_err", {31'b0, err}, 32'd0);
        chk("run4_busy_end", {31'b0, busy}, 32'd0);
        chk("run4_retired", {16'b0, retired_cnt}, 32'd4);
        chk("run4_queue", exp_q.size(), 32'd0);

        // Branching run of 5
        do_reset();
        addr_tab[0] = 0; addr_tab[1] = 4; addr_tab[2] = 0; addr_tab[3] = 4; addr_tab[4] = 8;
        push_exp(5);
        iv_cnt = 0;
        do_start(5);
        feed(1, 7, 5, 3, 7);
        chk("br_done", {31'b0, done}, 32'd1);
        chk("br_in_valid_cycles", iv_cnt, 32'd5);
        chk("br_retired", {16'b0, retired_cnt}, 32'd5);
        chk("br_queue", exp_q.size(), 32'd0);

        // First-result timeout
        do_reset();
        addr_tab[0] = 0; addr_tab[1] = 4; addr_tab[2] = 8;
        push_exp(3);
        do_start(3);
        feed(1, 10, 3, 99, 0);
        chk("to_err_early", {31'b0, err}, 32'd0);
        feed(11, 11, 3, 99, 0);
        chk("to_err", {31'b0, err}, 32'd1);
        chk("to_code", {29'b0, err_code}, 32'd1);
        chk("to_in_valid", {31'b0, in_valid}, 32'd0);
        chk("to_queue", exp_q.size(), 32'd0);

        // out_valid falls mid-run
        do_reset();
        addr_tab[0] = 0; addr_tab[1] = 4; addr_tab[2] = 8; addr_tab[3] = 12; addr_tab[4] = 0;
        push_exp(4);
        do_start(5);
        feed(1, 4, 5, 3, 4);
        chk("fell_err_early", {31'b0, err}, 32'd0);
        feed(5, 5, 5, 3, 4);
        chk("fell_err", {31'b0, err}, 32'd1);
        chk("fell_code", {29'b0, err_code}, 32'd2);
        chk("fell_retired", {16'b0, retired_cnt}, 32'd2);
        chk("fell_in_valid", {31'b0, in_valid}, 32'd0);
        feed(6, 7, 5, 6, 7);
        chk("fell_frozen", {16'b0, retired_cnt}, 32'd2);
        chk("fell_code_frozen", {29'b0, err_code}, 32'd2);
        chk("fell_queue", exp_q.size(), 32'd0);

        // Extra out_valid after completion
        do_reset();
        addr_tab[0] = 0; addr_tab[1] = 4;
        push_exp(2);
        do_start(2);
        feed(1, 4, 2, 3, 4);
        chk("extra_done", {31'b0, done}, 32'd1);
        feed(5, 5, 2, 5, 5);
        chk("extra_done_drop", {31'b0, done}, 32'd0);
        chk("extra_err", {31'b0, err}, 32'd1);
        chk("extra_code", {29'b0, err_code}, 32'd3);

        // Misaligned fetch address
        do_reset();
        addr_tab[0] = 32'h6;
        do_start(3);
        feed(1, 1, 1, 99, 0);
        chk("misal_err", {31'b0, err}, 32'd1);
        chk("misal_code", {29'b0, err_code}, 32'd4);
        chk("misal_in_valid", {31'b0, in_valid}, 32'd0);
        chk("misal_busy", {31'b0, busy}, 32'd0);

        // Out-of-range fetch address (first word past the ROM)
        do_reset();
        addr_tab[0] = 32'h800;
        do_start(3);
        feed(1, 1, 1, 99, 0);
        chk("range_code", {29'b0, err_code}, 32'd4);

        // Reset mid-FEED, then rerun from the retained program
        do_reset();
        addr_tab[0] = 0; addr_tab[1] = 4; addr_tab[2] = 8; addr_tab[3] = 12;
        push_exp(2);
        do_start(4);
        feed(1, 2, 4, 99, 0);
        rst_n = 1'b0;
        step();
        chk("midrst_in_valid", {31'b0, in_valid}, 32'd0);
        chk("midrst_inst", inst, 32'd0);
        chk("midrst_busy", {31'b0, busy}, 32'd0);
        chk("midrst_retired", {16'b0, retired_cnt}, 32'd0);
        chk("midrst_err", {31'b0, err}, 32'd0);
        rst_n = 1'b1;
        addr_tab[0] = 0;
        push_exp(1);
        do_start(1);
        feed(1, 3, 1, 3, 3);
        chk("rerun_done", {31'b0, done}, 32'd1);
        chk("rerun_retired", {16'b0, retired_cnt}, 32'd1);
        chk("rerun_queue", exp_q.size(), 32'd0);

        // Zero-length run
        do_reset();
        do_start(0);
        chk("zero_done", {31'b0, done}, 32'd1);
        chk("zero_busy", {31'b0, busy}, 32'd0);
        step();
        chk("zero_in_valid", {31'b0, in_valid}, 32'd0);
        chk("zero_queue", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
